// File: rtl/multi_pattern_seq_detector.sv
// Serial bit-stream detector matching up to NUM_PAT runtime-programmable patterns
// in parallel, each with its own length, enable, fill tracking and hit counter.

module mpsd_slot #(
  parameter int SEQ_W = 8,
  parameter int CNT_W = 8,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             we,
  input  logic [SEQ_W-1:0] wr_pattern,
  input  logic [LEN_W-1:0] wr_len,
  input  logic             wr_en,
  input  logic             overlap,
  input  logic             din_valid,
  input  logic [SEQ_W-1:0] new_hist,
  input  logic             cnt_clr,
  output logic             match,
  output logic             seen,
  output logic [CNT_W-1:0] cnt
);
  localparam logic [LEN_W-1:0] LMAX = LEN_W'(SEQ_W);

  logic [SEQ_W-1:0] pat, mask;
  logic [LEN_W-1:0] len, fill, fill_inc;
  logic             en;

  always_comb begin
    // a shift by SEQ_W or more yields an all-ones mask
    mask     = ~({SEQ_W{1'b1}} << len);
    fill_inc = (fill == LMAX) ? LMAX : fill + 1'b1;
    match    = din_valid && !we && en && (len != '0) && (len <= LMAX) &&
               (fill_inc >= len) && ((new_hist & mask) == (pat & mask));
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pat  <= '0;
      len  <= '0;
      en   <= 1'b0;
      fill <= '0;
      seen <= 1'b0;
      cnt  <= '0;
    end else begin
      if (we) begin
        pat  <= wr_pattern;
        len  <= wr_len;
        en   <= wr_en;
        fill <= '0;
      end else if (din_valid) begin
        fill <= (match && !overlap) ? '0 : fill_inc;
      end
      seen <= match;
      if (cnt_clr)                  cnt <= '0;
      else if (match && cnt != '1)  cnt <= cnt + 1'b1;
    end
  end
endmodule

module multi_pattern_seq_detector #(
  parameter int SEQ_W   = 8,
  parameter int NUM_PAT = 4,
  parameter int CNT_W   = 8,
  parameter int IDX_W   = (NUM_PAT > 1) ? $clog2(NUM_PAT) : 1,
  parameter int LEN_W   = $clog2(SEQ_W + 1)
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               cfg_we,
  input  logic [IDX_W-1:0]   cfg_idx,
  input  logic [SEQ_W-1:0]   cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_en,
  input  logic               overlap,
  input  logic               din_valid,
  input  logic               din,
  input  logic               cnt_clr,
  input  logic [IDX_W-1:0]   cnt_idx,
  output logic [NUM_PAT-1:0] seen,
  output logic               seen_any,
  output logic [CNT_W-1:0]   hit_cnt
);
  // the oldest history bit is never compared, so only SEQ_W-1 bits are stored
  logic [SEQ_W-2:0]              hist;
  logic [SEQ_W-1:0]              new_hist;
  logic [NUM_PAT-1:0]            match;
  logic [NUM_PAT-1:0][CNT_W-1:0] cnt_all;

  assign new_hist = {hist, din};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hist     <= '0;
      seen_any <= 1'b0;
    end else begin
      if (din_valid) hist <= new_hist[SEQ_W-2:0];
      seen_any <= |match;
    end
  end

  for (genvar i = 0; i < NUM_PAT; i++) begin : g_slot
    mpsd_slot #(.SEQ_W(SEQ_W), .CNT_W(CNT_W), .LEN_W(LEN_W)) u_slot (
      .clk        (clk),
      .resetn     (resetn),
      .we         (cfg_we && (cfg_idx == IDX_W'(i))),
      .wr_pattern (cfg_pattern),
      .wr_len     (cfg_len),
      .wr_en      (cfg_en),
      .overlap    (overlap),
      .din_valid  (din_valid),
      .new_hist   (new_hist),
      .cnt_clr    (cnt_clr),
      .match      (match[i]),
      .seen       (seen[i]),
      .cnt        (cnt_all[i])
    );
  end

  always_comb begin
    hit_cnt = '0;
    for (int i = 0; i < NUM_PAT; i++)
      if (cnt_idx == IDX_W'(i)) hit_cnt = cnt_all[i];
  end
endmodule

// File: tb/tb_multi_pattern_seq_detector.sv
// Scoreboard bench: stimulus pushes the expected seen vector (and optionally the
// selected hit count) for every clock; a monitor pops and compares after each edge.

module tb_multi_pattern_seq_detector;
  logic       clk = 1'b0;
  logic       resetn;
  logic       cfg_we;
  logic [1:0] cfg_idx;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       cfg_en;
  logic       overlap;
  logic       din_valid;
  logic       din;
  logic       cnt_clr;
  logic [1:0] cnt_idx;
  logic [3:0] seen;
  logic       seen_any;
  logic [1:0] hit_cnt;

  typedef struct {
    logic [3:0] seen;
    logic       chk;
    logic [1:0] cnt;
    int         id;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   step  = 0;

  multi_pattern_seq_detector #(.SEQ_W(8), .NUM_PAT(4), .CNT_W(2)) dut (
    .clk(clk), .resetn(resetn), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_en(cfg_en),
    .overlap(overlap), .din_valid(din_valid), .din(din), .cnt_clr(cnt_clr),
    .cnt_idx(cnt_idx), .seen(seen), .seen_any(seen_any), .hit_cnt(hit_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin : monitor
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      total++;
      if (seen !== e.seen || seen_any !== (|e.seen)) begin
        bad++;
        $display("FAIL seen step=%0d got seen=%b any=%b want seen=%b any=%b",
                 e.id, seen, seen_any, e.seen, |e.seen);
      end
      if (e.chk) begin
        total++;
        if (hit_cnt !== e.cnt) begin
          bad++;
          $display("FAIL hit_cnt step=%0d idx=%0d got=%0d want=%0d",
                   e.id, cnt_idx, hit_cnt, e.cnt);
        end
      end
    end
  end

  task automatic cyc(input logic v, input logic d, input logic [3:0] es,
                     input logic chk, input logic [1:0] ec);
    exp_t e;
    din_valid = v;
    din       = d;
    e.seen = es; e.chk = chk; e.cnt = ec; e.id = step;
    step++;
    q.push_back(e);
    @(posedge clk);
    #2;
    din_valid = 1'b0;
  endtask

  task automatic beat(input logic d, input logic [3:0] es);
    cyc(1'b1, d, es, 1'b0, 2'd0);
  endtask

  task automatic beatc(input logic d, input logic [3:0] es, input logic [1:0] ec);
    cyc(1'b1, d, es, 1'b1, ec);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 4'b0000, 1'b0, 2'd0);
  endtask

  task automatic cfg(input int idx, input logic [7:0] p, input logic [3:0] l,
                     input logic e);
    cfg_we = 1'b1; cfg_idx = 2'(idx); cfg_pattern = p; cfg_len = l; cfg_en = e;
    cyc(1'b0, 1'b0, 4'b0000, 1'b0, 2'd0);
    cfg_we = 1'b0;
  endtask

  task automatic clr();
    cnt_clr = 1'b1;
    cyc(1'b0, 1'b0, 4'b0000, 1'b1, 2'd0);
    cnt_clr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    resetn = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_pattern = '0; cfg_len = '0;
    cfg_en = 1'b0; overlap = 1'b1; din_valid = 1'b0; din = 1'b0;
    cnt_clr = 1'b0; cnt_idx = '0;
    cyc(1'b0, 1'b0, 4'b0000, 1'b1, 2'd0);
    cyc(1'b0, 1'b0, 4'b0000, 1'b1, 2'd0);
    resetn = 1'b1;
    // reset state with stream running but nothing programmed
    beatc(1'b1, 4'b0000, 2'd0);

    // 1: 1011 len 4
    cfg(0, 8'b0000_1011, 4'd4, 1'b1);
    clr();
    beat(1'b1, 4'b0000); beat(1'b0, 4'b0000); beatc(1'b1, 4'b0000, 2'd0);
    beatc(1'b1, 4'b0001, 2'd1);
    cyc(1'b0, 1'b0, 4'b0000, 1'b1, 2'd1);

    // 2: 101 len 3, overlap then non-overlap
    cfg(0, 8'b0000_0101, 4'd3, 1'b1);
    clr();
    overlap = 1'b1;
    beat(1'b1, 4'b0000); beat(1'b0, 4'b0000); beatc(1'b1, 4'b0001, 2'd1);
    beat(1'b0, 4'b0000); beatc(1'b1, 4'b0001, 2'd2);
    cfg(0, 8'b0000_0101, 4'd3, 1'b1);
    overlap = 1'b0;
    beat(1'b1, 4'b0000); beat(1'b0, 4'b0000); beatc(1'b1, 4'b0001, 2'd3);
    beat(1'b0, 4'b0000); beatc(1'b1, 4'b0000, 2'd3);

    // 3: same streams with 0-3 clk gaps
    cfg(0, 8'b0000_0101, 4'd3, 1'b1);
    clr();
    overlap = 1'b1;
    beat(1'b1, 4'b0000); beat(1'b0, 4'b0000); idle(1);
    beat(1'b1, 4'b0001); idle(2);
    beat(1'b0, 4'b0000); idle(3);
    beatc(1'b1, 4'b0001, 2'd2);
    cfg(0, 8'b0000_0101, 4'd3, 1'b1);
    overlap = 1'b0;
    beat(1'b1, 4'b0000); idle(3); beat(1'b0, 4'b0000); idle(1);
    beat(1'b1, 4'b0001); idle(2); beat(1'b0, 4'b0000);
    beatc(1'b1, 4'b0000, 2'd3);

    // 4: slot1 11 len 2, saturating 2-bit counter, clear beats hit
    cfg(0, 8'h00, 4'd0, 1'b0);
    cfg(1, 8'b0000_0011, 4'd2, 1'b1);
    overlap = 1'b1;
    cnt_idx = 2'd1;
    clr();
    beatc(1'b1, 4'b0000, 2'd0);
    beatc(1'b1, 4'b0010, 2'd1);
    beatc(1'b1, 4'b0010, 2'd2);
    beatc(1'b1, 4'b0010, 2'd3);
    beatc(1'b1, 4'b0010, 2'd3);
    beatc(1'b1, 4'b0010, 2'd3);
    cnt_clr = 1'b1;
    beatc(1'b1, 4'b0010, 2'd0);
    cnt_clr = 1'b0;
    beatc(1'b0, 4'b0000, 2'd0);

    // 5: partial 1,0 then reset; a fresh 1 alone must not hit
    cfg(1, 8'h00, 4'd0, 1'b0);
    cfg(0, 8'b0000_0101, 4'd3, 1'b1);
    cnt_idx = 2'd0;
    clr();
    beat(1'b1, 4'b0000); beat(1'b0, 4'b0000);
    resetn = 1'b0;
    cyc(1'b0, 1'b0, 4'b0000, 1'b1, 2'd0);
    resetn = 1'b1;
    cfg(0, 8'b0000_0101, 4'd3, 1'b1);
    beatc(1'b1, 4'b0000, 2'd0);
    beat(1'b0, 4'b0000);
    beatc(1'b1, 4'b0001, 2'd1);

    // 6: lengths 1, 3, 8, 0; stream 1,0,0,1,0,0,1,1
    cfg(0, 8'b0000_0001, 4'd1, 1'b1);
    cfg(1, 8'b0000_0011, 4'd3, 1'b1);
    cfg(2, 8'b1001_0011, 4'd8, 1'b1);
    cfg(3, 8'b1111_1111, 4'd0, 1'b1);
    cnt_idx = 2'd2;
    clr();
    beat(1'b1, 4'b0001); beat(1'b0, 4'b0000); beat(1'b0, 4'b0000);
    beat(1'b1, 4'b0001); beat(1'b0, 4'b0000); beat(1'b0, 4'b0000);
    beat(1'b1, 4'b0001);
    cfg_we = 1'b1; cfg_idx = 2'd2; cfg_pattern = 8'b1001_0011; cfg_len = 4'd8;
    cfg_en = 1'b1;
    beatc(1'b1, 4'b0011, 2'd0);
    cfg_we = 1'b0;
    // slot2 needs a full fresh 8 bits after the rewrite
    beat(1'b1, 4'b0001); beat(1'b0, 4'b0000); beat(1'b0, 4'b0000);
    beat(1'b1, 4'b0001); beat(1'b0, 4'b0000); beat(1'b0, 4'b0000);
    beat(1'b1, 4'b0001);
    beatc(1'b1, 4'b0111, 2'd1);
    cnt_idx = 2'd3;
    cyc(1'b0, 1'b0, 4'b0000, 1'b1, 2'd0);

    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    #3;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d pending want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
